// File: rtl/mp64_mbox_pkg.sv
// Shared MP64 mailbox/spinlock constants: core counts, region bases and register offsets.
package mp64_mbox_pkg;

  localparam int NUM_CORES      = 4;
  localparam int CORE_ID_BITS   = 2;
  localparam int NUM_SPINLOCKS  = 16;
  localparam int SLOCK_IDX_BITS = $clog2(NUM_SPINLOCKS);

  localparam logic [11:0] MBOX_BASE  = 12'h500;
  localparam logic [11:0] SLOCK_BASE = 12'h600;

  // Mailbox register offsets; 0x00..MBOX_DATA_LAST are the data bytes.
  localparam logic [7:0] MBOX_DATA_LAST = 8'h07;
  localparam logic [7:0] MBOX_SEND      = 8'h08;
  localparam logic [7:0] MBOX_STATUS    = 8'h09;
  localparam logic [7:0] MBOX_ACK       = 8'h0A;

  // Per-lock register offsets (addr[1:0] within each 4-byte lock slot).
  typedef enum logic [1:0] {
    SLOCK_ACQUIRE = 2'd0,
    SLOCK_RELEASE = 2'd1,
    SLOCK_STATUS  = 2'd2,
    SLOCK_RSVD    = 2'd3
  } slock_reg_e;

endpackage

// File: rtl/mp64_mbox.sv
// Inter-core mailbox: per-core 64-bit data, IPI pending matrix with acknowledge,
// and owner-tracked test-and-set spinlocks, all behind a byte-wide MMIO port.
module mp64_mbox
  import mp64_mbox_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic [11:0]             addr,
  input  logic [7:0]              wdata,
  input  logic                    wen,
  output logic [7:0]              rdata,
  output logic                    ack,
  input  logic [CORE_ID_BITS-1:0] requester_id,
  output logic [NUM_CORES-1:0]    ipi_out
);

  logic [7:0][7:0]                          data_q [NUM_CORES];
  // pending_q[target][sender]
  logic [NUM_CORES-1:0][NUM_CORES-1:0]      pending_q;
  logic [NUM_CORES-1:0][NUM_CORES-1:0]      pending_d;

  // Names kept unsuffixed so they can be probed by hierarchical path.
  logic                                     slock_locked [NUM_SPINLOCKS];
  logic [CORE_ID_BITS-1:0]                  slock_owner  [NUM_SPINLOCKS];

  logic                      mbox_hit;
  logic [7:0]                mbox_reg;
  logic                      mbox_data_reg;
  logic [5:0]                lock_idx;
  logic [SLOCK_IDX_BITS-1:0] lock_sel;
  logic                      slock_hit;
  slock_reg_e                slock_reg;
  logic                      slock_busy;

  assign ack           = req;
  assign mbox_hit      = (addr[11:8] == MBOX_BASE[11:8]);
  assign mbox_reg      = addr[7:0];
  assign mbox_data_reg = (mbox_reg <= MBOX_DATA_LAST);
  assign lock_idx      = addr[7:2];
  assign lock_sel      = lock_idx[SLOCK_IDX_BITS-1:0];
  // Lock slots beyond the implemented count behave as unmapped space.
  assign slock_hit     = (addr[11:8] == SLOCK_BASE[11:8]) && (lock_idx < 6'(NUM_SPINLOCKS));
  assign slock_reg     = slock_reg_e'(addr[1:0]);
  assign slock_busy    = slock_locked[lock_sel] && (slock_owner[lock_sel] != requester_id);

  // Read mux: purely combinational from address, requester and current state.
  always_comb begin
    rdata = 8'h00;
    if (mbox_hit) begin
      if (mbox_data_reg) begin
        rdata = data_q[requester_id][mbox_reg[2:0]];
      end else if (mbox_reg == MBOX_STATUS) begin
        rdata = 8'(pending_q[requester_id]);
      end
    end else if (slock_hit) begin
      case (slock_reg)
        SLOCK_ACQUIRE: rdata = {7'b0, slock_busy};
        SLOCK_STATUS:  rdata = 8'({slock_owner[lock_sel], slock_locked[lock_sel]});
        default:       rdata = 8'h00;
      endcase
    end
  end

  // IPI matrix next state: SEND sets [target][me], ACK clears [me][sender].
  always_comb begin
    pending_d = pending_q;
    if (req && wen && mbox_hit) begin
      if (mbox_reg == MBOX_SEND) begin
        pending_d[wdata[CORE_ID_BITS-1:0]][requester_id] = 1'b1;
      end else if (mbox_reg == MBOX_ACK) begin
        pending_d[requester_id][wdata[CORE_ID_BITS-1:0]] = 1'b0;
      end
    end
  end

  // Each core's IPI line stays up while any sender is still unacknowledged.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      ipi_out[i] = |pending_q[i];
    end
  end

  // Mailbox data and pending matrix registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '{default: '0};
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
      if (req && wen && mbox_hit && mbox_data_reg) begin
        data_q[requester_id][mbox_reg[2:0]] <= wdata;
      end
    end
  end

  // Spinlocks: acquire is a read with side effect; release only by the owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPINLOCKS; i++) begin
        slock_locked[i] <= 1'b0;
        slock_owner[i]  <= '0;
      end
    end else if (req && slock_hit) begin
      case (slock_reg)
        SLOCK_ACQUIRE: begin
          if (!wen && !slock_busy) begin
            slock_locked[lock_sel] <= 1'b1;
            slock_owner[lock_sel]  <= requester_id;
          end
        end
        SLOCK_RELEASE: begin
          if (wen && (slock_owner[lock_sel] == requester_id)) begin
            slock_locked[lock_sel] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mp64_mbox.sv
// Directed bench for mp64_mbox: vector table plus hand-written multi-cycle sequences.
module tb_mp64_mbox;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [11:0] addr;
  logic [7:0]  wdata;
  logic        wen;
  logic [7:0]  rdata;
  logic        ack;
  logic [1:0]  requester_id;
  logic [3:0]  ipi_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mp64_mbox dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .addr         (addr),
    .wdata        (wdata),
    .wen          (wen),
    .rdata        (rdata),
    .ack          (ack),
    .requester_id (requester_id),
    .ipi_out      (ipi_out)
  );

  typedef struct {
    logic [1:0]  rid;
    logic        wen;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic        chk_rd;
    logic [7:0]  exp_rd;
    logic        chk_ipi;
    logic [3:0]  exp_ipi;
  } vec_t;

  vec_t tbl[$];

  function automatic void wr(input int rid, input int a, input int d, input int ipi = -1);
    vec_t v;
    v.rid = 2'(rid); v.wen = 1'b1; v.addr = 12'(a); v.wdata = 8'(d);
    v.chk_rd = 1'b0; v.exp_rd = 8'h00;
    v.chk_ipi = (ipi >= 0); v.exp_ipi = 4'(ipi);
    tbl.push_back(v);
  endfunction

  function automatic void rd(input int rid, input int a, input int e, input int ipi = -1);
    vec_t v;
    v.rid = 2'(rid); v.wen = 1'b0; v.addr = 12'(a); v.wdata = 8'h00;
    v.chk_rd = 1'b1; v.exp_rd = 8'(e);
    v.chk_ipi = (ipi >= 0); v.exp_ipi = 4'(ipi);
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Drive one access just after a rising edge, sample mid-cycle; the next
  // rising edge commits it.
  task automatic access(input logic [1:0] rid, input logic w, input logic [11:0] a,
                        input logic [7:0] d);
    @(posedge clk);
    #1;
    req = 1'b1; wen = w; requester_id = rid; addr = a; wdata = d;
    #3;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    req = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
    #3;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; wen = 1'b0; addr = '0; wdata = '0; requester_id = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #3;

    // Reset state
    chk("reset_ipi", 8'(ipi_out), 8'h00);
    chk("reset_ack_idle", 8'(ack), 8'h00);
    chk("reset_lock0", 8'(dut.slock_locked[0]), 8'h00);

    // Mailbox data, per-core independence
    wr(0, 'h500, 'h42);
    wr(1, 'h500, 'hFF);
    rd(0, 'h500, 'h42);
    rd(1, 'h500, 'hFF);
    rd(2, 'h500, 'h00);
    wr(0, 'h507, 'hA5);
    rd(0, 'h507, 'hA5);
    rd(0, 'h506, 'h00);
    // IPI send / ack
    wr(0, 'h508, 'h01, 'b0000);
    rd(1, 'h509, 'h01, 'b0010);
    wr(1, 'h50A, 'h00, 'b0010);
    rd(1, 'h509, 'h00, 'b0000);
    // Broadcast
    wr(0, 'h508, 'h01);
    wr(0, 'h508, 'h02);
    wr(0, 'h508, 'h03);
    rd(2, 'h509, 'h01, 'b1110);
    wr(1, 'h50A, 'h00, 'b1110);
    wr(2, 'h50A, 'h00, 'b1100);
    wr(3, 'h50A, 'h00, 'b1000);
    rd(3, 'h509, 'h00, 'b0000);
    // Multiple senders to core3
    wr(0, 'h508, 'h03);
    wr(2, 'h508, 'h03);
    rd(3, 'h509, 'h05, 'b1000);
    wr(3, 'h50A, 'h00, 'b1000);
    rd(3, 'h509, 'h04, 'b1000);
    wr(3, 'h50A, 'h02, 'b1000);
    rd(0, 'h509, 'h00, 'b0000);
    // Send to self
    wr(2, 'h508, 'h02, 'b0000);
    rd(2, 'h509, 'h04, 'b0100);
    wr(2, 'h50A, 'h02, 'b0100);
    rd(2, 'h509, 'h00, 'b0000);
    // Unmapped space
    rd(0, 'h50B, 'h00);
    wr(0, 'h700, 'h55);
    rd(0, 'h700, 'h00);
    rd(0, 'h400, 'h00);
    // Spinlock contention and re-entry
    rd(0, 'h600, 'h00);
    rd(1, 'h600, 'h01);
    rd(0, 'h602, 'h01);
    wr(0, 'h601, 'h00);
    rd(1, 'h600, 'h00);
    rd(0, 'h600, 'h01);
    rd(1, 'h602, 'h03);
    rd(2, 'h604, 'h00);
    rd(2, 'h604, 'h00);
    rd(0, 'h604, 'h01);
    // Independent locks 2 and 3
    rd(0, 'h608, 'h00);
    rd(1, 'h60C, 'h00);
    rd(1, 'h608, 'h01);
    rd(0, 'h60C, 'h01);
    rd(0, 'h60F, 'h00);

    foreach (tbl[i]) begin
      access(tbl[i].rid, tbl[i].wen, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("ack[%0d]", i), 8'(ack), 8'h01);
      if (tbl[i].chk_rd)  chk($sformatf("rdata[%0d]", i), rdata, tbl[i].exp_rd);
      if (tbl[i].chk_ipi) chk($sformatf("ipi[%0d]", i), 8'(ipi_out), 8'(tbl[i].exp_ipi));
    end
    idle();
    chk("ack_idle", 8'(ack), 8'h00);

    // Ownership: only the owner can release lock5
    access(2'd3, 1'b0, 12'h614, 8'h00);
    chk("l5_acq_c3", rdata, 8'h00);
    idle();
    chk("l5_owner", 8'(dut.slock_owner[5]), 8'h03);
    chk("l5_locked", 8'(dut.slock_locked[5]), 8'h01);
    access(2'd0, 1'b1, 12'h615, 8'h00);
    idle();
    chk("l5_nonowner_rel", 8'(dut.slock_locked[5]), 8'h01);
    access(2'd0, 1'b0, 12'h614, 8'h00);
    chk("l5_busy_c0", rdata, 8'h01);
    access(2'd3, 1'b1, 12'h615, 8'h00);
    idle();
    chk("l5_owner_rel", 8'(dut.slock_locked[5]), 8'h00);
    access(2'd0, 1'b0, 12'h614, 8'h00);
    chk("l5_acq_c0", rdata, 8'h00);
    access(2'd1, 1'b0, 12'h616, 8'h00);
    chk("l5_status", rdata, 8'h01);

    // Reset during a concurrent SEND: reset wins and clears everything
    access(2'd1, 1'b1, 12'h508, 8'h00);
    idle();
    chk("pre_rst_ipi", 8'(ipi_out), 8'h01);
    @(posedge clk);
    #1;
    rst = 1'b1; req = 1'b1; wen = 1'b1; requester_id = 2'd2; addr = 12'h508; wdata = 8'h03;
    @(posedge clk);
    #1;
    rst = 1'b0; req = 1'b0; wen = 1'b0;
    #3;
    chk("rst_ipi", 8'(ipi_out), 8'h00);
    chk("rst_l5", 8'(dut.slock_locked[5]), 8'h00);
    access(2'd0, 1'b0, 12'h500, 8'h00);
    chk("rst_data", rdata, 8'h00);
    access(2'd1, 1'b0, 12'h616, 8'h00);
    chk("rst_l5_status", rdata, 8'h00);
    access(2'd3, 1'b0, 12'h509, 8'h00);
    chk("rst_status", rdata, 8'h00);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mp64_mbox.md
# mp64_mbox

Inter-core mailbox and hardware spinlock block for the MP64 multi-core system. It sits behind the shared MMIO arbiter, which presents one core's byte-wide access per cycle tagged with the requester's core ID. The block provides:
- per-core 64-bit mailbox data registers;
- inter-processor interrupts (IPIs) with per-sender pending bits and acknowledge;
- an array of owner-tracked test-and-set spinlocks.

## Interface
Parameters (global constants from the shared defs include, not module-local):
- NUM_CORES, 4, number of cores and width of ipi_out
- CORE_ID_BITS, 2, width of a core ID
- NUM_SPINLOCKS, 16, spinlock count, 4 bytes of address space each
- MBOX_SEND / MBOX_STATUS / MBOX_ACK, 0x08 / 0x09 / 0x0A, mailbox register offsets

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous and active-high
- req  in  1  access strobe, one access per cycle it is high
- addr  in  12  MMIO offset within the system MMIO page
- wdata  in  8  write data
- wen  in  1  1 = write, 0 = read
- rdata  out  8  read data, combinational
- ack  out  1  access acknowledge, combinational
- requester_id  in  CORE_ID_BITS  issuing core
- ipi_out  out  NUM_CORES  per-core IPI request lines

## Operation
Address decoding:
- Mailbox region: addr[11:8] = 0x5, register = addr[7:0].
- Spinlock region: addr[11:8] = 0x6, lock = addr[7:2], register = addr[1:0].
- Any other address: reads return 0x00, writes are ignored, ack is still asserted.

Mailbox data:
- Offsets 0x00–0x07 select byte n of data[requester_id] for both read and write.
- Each core's data register is independent of every other core's.

IPI state: pending[target][sender], a NUM_CORES×NUM_CORES bit matrix.
- Write MBOX_SEND: target = wdata[CORE_ID_BITS-1:0]; sets pending[target][requester_id]. Sending to self is legal.
- Read MBOX_STATUS: returns pending[requester_id] in bits [NUM_CORES-1:0]; upper bits are 0.
- Write MBOX_ACK: sender = wdata[CORE_ID_BITS-1:0]; clears pending[requester_id][sender]. Other pending bits are untouched.
- ipi_out[i] = OR of pending[i]. The line stays high until every sender to core i has been acknowledged.
- Reads of other unmapped mailbox offsets return 0x00.

Spinlocks: state arrays slock_locked[NUM_SPINLOCKS] and slock_owner[NUM_SPINLOCKS]. These signal names are required because benches probe them hierarchically.
- Read offset 0 (ACQUIRE), lock free or already owned by the requester: returns 0x00, sets locked and owner = requester. Re-entry by the owner is allowed; there is no nesting count.
- Read offset 0 (ACQUIRE), lock held by another core: returns 0x01, no state change.
- Write offset 1 (RELEASE): clears locked only if owner == requester. A release from a non-owner is silently ignored.
- Read offset 2 (STATUS): returns {5'b0, owner, locked}; it is non-destructive.
- Writes to offsets 0, 2 and 3 are ignored; reads of offset 3 return 0x00.

## Timing
- ack = req, combinationally.
- rdata is combinational from addr, requester_id and current state; it is valid in the same cycle as req.
- State updates (data, pending, lock) occur at the rising clk edge where req is high; spinlock acquire is a read with a side effect.
- ipi_out is combinational from registered pending. It rises or falls in the cycle after the SEND or ACK edge.
- The upstream arbiter guarantees at most one access per cycle, so simultaneous operations from different cores cannot occur.
- Reset clears all data registers, the pending matrix, slock_locked and slock_owner. Consequently ipi_out = 0 and rdata reflects cleared state.
- Reset asserted mid-operation wins over any concurrent access.

## Structure
- The shared defs include holds NUM_CORES, CORE_ID_BITS, NUM_SPINLOCKS, the MBOX_* and SLOCK_* offsets, and the region bases 0x500 and 0x600.
- Single module with no sub-modules. The spinlock array may optionally be factored into mp64_spinlock_bank.

## Test plan
- Mailbox data: core0 writes 0x42 to 0x500 and core1 writes 0xFF to 0x500. Core0 reads back 0x42 and core1 reads back 0xFF.
- IPI send and acknowledge:
  - core0 writes 0x01 to 0x508 → ipi_out = 0010, and core1's read of 0x509 gives low nibble 0x1;
  - core1 then writes 0x00 to 0x50A → ipi_out = 0000 and status reads 0x0.
- IPI broadcast: core0 sends to cores 1, 2 and 3 → ipi_out = 1110. Each target ACKs sender 0 → ipi_out = 0000.
- Multiple senders:
  - cores 0 and 2 send to core3 → core3 status = 0x05;
  - ACK sender 0 → ipi_out stays 1000;
  - ACK sender 2 → ipi_out = 0000.
- Spinlock contention:
  - core0 reads 0x600 → 0x00; core1 reads 0x600 → 0x01;
  - core0 writes 0x601 → core1's next read of 0x600 returns 0x00, and core0's read then returns 0x01;
  - core2 reading lock1 (0x604) twice returns 0x00 both times (re-entry).
- Spinlock independence and ownership:
  - locks 2 and 3 are held by different cores, and each is busy for the other core;
  - core3 acquires lock5 (0x614) → slock_owner[5] = 3;
  - core0 writes 0x615 → lock stays held;
  - core3 writes 0x615 → slock_locked[5] = 0.
